// File: rtl/tile_writeback_if.sv
// Feature-map SRAM write port: one beat carries one tile row with a
// per-byte column mask. The master drives beats, the slave (SRAM) accepts them.
interface tile_writeback_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_SIZE = 16,
  parameter int ADDR_W     = 16
);
  logic                             wr_valid;
  logic                             wr_ready;
  logic [ADDR_W-1:0]                wr_addr;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] wr_data;
  logic [ARRAY_SIZE-1:0]            wr_mask;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output wr_mask,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  wr_mask,
    output wr_ready
  );
endinterface

// File: rtl/tile_writeback.sv
// Tile write-back stage: on a rising edge of processing_done the finished
// int8 tile is copied into a local buffer (freeing the upstream array for the
// next tile), then streamed row by row to the feature-map SRAM with strided
// word addressing and a per-byte column mask.
module tile_writeback #(
  parameter  int DATA_WIDTH = 8,
  parameter  int ARRAY_SIZE = 16,
  parameter  int ADDR_W     = 16,
  localparam int CNT_W      = $clog2(ARRAY_SIZE + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_processing_done,
  input  logic [DATA_WIDTH-1:0] i_tile_in [ARRAY_SIZE][ARRAY_SIZE],
  input  logic [CNT_W-1:0]      i_num_rows,
  input  logic [CNT_W-1:0]      i_num_cols,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [ADDR_W-1:0]     i_row_stride,
  tile_writeback_if.master      wr,
  output logic                  o_busy,
  output logic                  o_tile_consumed,
  output logic                  o_wb_done,
  output logic                  o_overrun
);

  localparam int IDX_W = $clog2(ARRAY_SIZE);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_WRITE   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(ARRAY_SIZE);

  // Control state
  logic [1:0]        r_state;
  logic              r_pd_q;
  logic              r_overrun;

  // Per-tile parameters latched at capture time
  logic [CNT_W-1:0]  r_num_rows;
  logic [CNT_W-1:0]  r_num_cols;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_stride;

  // Beat registers (held stable while the SRAM stalls)
  logic [IDX_W-1:0]                 r_row;
  logic [ADDR_W-1:0]                r_wr_addr;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] r_wr_data;
  logic [ARRAY_SIZE-1:0]            r_wr_mask;

  // Captured tile
  logic [DATA_WIDTH-1:0] r_buf [ARRAY_SIZE][ARRAY_SIZE];

  logic                             w_edge;
  logic                             w_ready_for_tile;
  logic                             w_capture;
  logic                             w_empty;
  logic                             w_last_row;
  logic [CNT_W-1:0]                 w_rows_clamped;
  logic [CNT_W-1:0]                 w_cols_clamped;
  logic [IDX_W-1:0]                 w_sel_row;
  logic [ARRAY_SIZE*DATA_WIDTH-1:0] w_row_data;
  logic [ARRAY_SIZE-1:0]            w_col_mask;

  assign w_edge           = i_processing_done & ~r_pd_q;
  // A new tile may be taken in IDLE and also in the single DONE cycle.
  assign w_ready_for_tile = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_capture        = w_edge & w_ready_for_tile & ~i_clr;
  assign w_empty          = (r_num_rows == '0) || (r_num_cols == '0);
  assign w_last_row       = (CNT_W'(r_row) == (r_num_rows - CNT_W'(1)));
  assign w_rows_clamped   = (i_num_rows > MAX_CNT) ? MAX_CNT : i_num_rows;
  assign w_cols_clamped   = (i_num_cols > MAX_CNT) ? MAX_CNT : i_num_cols;

  // Row to load into the beat registers: row 0 when leaving CAPTURE,
  // otherwise the row after the one just accepted.
  assign w_sel_row = (r_state == S_WRITE) ? (r_row + IDX_W'(1)) : '0;

  // Pack the selected buffer row into a beat (column 0 in the LSBs) and build the column mask.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_row_data = '0;
    w_col_mask = '0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      w_row_data[c*DATA_WIDTH +: DATA_WIDTH] = r_buf[w_sel_row][c];
      w_col_mask[c]                          = (CNT_W'(c) < r_num_cols);
    end
  end

  // Copy the incoming tile into the local buffer on an accepted edge.
  always_ff @(posedge clk) begin
    // NOTE: the tile buffer has no reset; its contents only matter after a capture,
    // and leaving it out of reset keeps it a plain register file.
    if (w_capture) begin
      r_buf <= i_tile_in;
    end
  end

  // Main FSM: edge detect, parameter latch, beat sequencing and overrun tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pd_q     <= 1'b0;
      r_overrun  <= 1'b0;
      r_num_rows <= '0;
      r_num_cols <= '0;
      r_base     <= '0;
      r_stride   <= '0;
      r_row      <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
    end else if (i_clr) begin
      // Clear wins over any edge or handshake in the same cycle.
      r_state    <= S_IDLE;
      r_pd_q     <= 1'b0;
      r_overrun  <= 1'b0;
      r_row      <= '0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_mask  <= '0;
    end else begin
      r_pd_q <= i_processing_done;

      // A tile that shows up while the previous one is still in flight is dropped.
      if (w_edge && !w_ready_for_tile) begin
        r_overrun <= 1'b1;
      end

      if (w_capture) begin
        r_num_rows <= w_rows_clamped;
        r_num_cols <= w_cols_clamped;
        r_base     <= i_base_addr;
        r_stride   <= i_row_stride;
      end

      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_state <= S_CAPTURE;
          end
        end

        S_CAPTURE: begin
          if (w_empty) begin
            r_state <= S_DONE;
          end else begin
            r_state   <= S_WRITE;
            r_row     <= '0;
            r_wr_addr <= r_base;
            r_wr_data <= w_row_data;
            r_wr_mask <= w_col_mask;
          end
        end

        S_WRITE: begin
          if (wr.wr_ready) begin
            r_row     <= r_row + IDX_W'(1);
            r_wr_addr <= r_wr_addr + r_stride;
            r_wr_data <= w_row_data;
            if (w_last_row) begin
              r_state <= S_DONE;
            end
          end
        end

        S_DONE: begin
          r_state <= w_edge ? S_CAPTURE : S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Status and valid decode straight from the state register.
  assign o_busy          = (r_state == S_CAPTURE) || (r_state == S_WRITE);
  assign o_tile_consumed = (r_state == S_CAPTURE);
  assign o_wb_done       = (r_state == S_DONE);
  assign o_overrun       = r_overrun;

  assign wr.wr_valid = (r_state == S_WRITE);
  assign wr.wr_addr  = r_wr_addr;
  assign wr.wr_data  = r_wr_data;
  assign wr.wr_mask  = r_wr_mask;

endmodule
